i2s_frame_buf: RTL

- Successor to the stereo I2S capture register; runs in the serial-clock (sck) domain after the I2S deserialiser.
- Collects per-channel sample words into complete frames of NUM_CH channels (stereo or TDM).
- Applies a per-frame mode (pass, channel reverse, mute) and queues frames in a DEPTH-frame FIFO.
- Downstream reads frames through a valid/ready handshake; overflow and framing errors are flagged.

---
 rtl/i2s_frame_buf.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_frame_buf.sv
// i2s_frame_buf
//   Turns per-channel I2S sample words into complete NUM_CH-channel frames,
//   applies a per-frame mode (pass / reverse / mute) when the frame commits,
//   and queues the frames in a DEPTH-frame FIFO that is read with valid/ready.
//   Everything runs on the posedge of the serial clock.
//
// Ports
//   sck        clock (posedge)
//   rst_n      asynchronous active-low reset
//   data       incoming sample word
//   in_vld     data is valid this cycle
//   in_ch      channel index of data (0 = first/left)
//   mode       00 pass, 01 reverse channel order, 10 mute, 11 pass
//   out_frame  head frame, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_vld    head frame is valid
//   out_rdy    consumer accepts the head frame
//   level      number of frames stored (0..DEPTH)
//   overflow   sticky: a complete frame was dropped because the FIFO was full
//   clr_ovf    clears overflow (a simultaneous set wins)
//   frame_err  one-cycle pulse after a channel-sequence error
module i2s_frame_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                         sck,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic                         in_vld,
  input  logic [CH_W-1:0]              in_ch,
  input  logic [1:0]                   mode,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_frame,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [LVL_W-1:0]             level,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic                         frame_err
);

  localparam int FW    = NUM_CH * DATA_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {S_IDLE, S_COLLECT} asm_state_t;
  typedef enum logic [1:0] {M_PASS = 2'b00, M_REV = 2'b01, M_MUTE = 2'b10, M_PASS2 = 2'b11} mode_t;

  typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] frame_t;

  // Assembly state
  asm_state_t      state;
  logic [CH_W-1:0] expected_ch;
  frame_t          slots;

  // FIFO state
  logic [FW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // Combinational decode
  logic             word_ok, commit, pop, push, ovf_set, head_from_push;
  frame_t           raw_frame, xf_frame;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [LVL_W-1:0] lvl_next;
  logic [FW-1:0]    head_next;

  // In IDLE only a channel-0 word is in sequence; otherwise it must match the
  // expected channel. Out-of-range indices can never match.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    word_ok = 1'b0;
    if (in_vld) begin
      if (state == S_IDLE) word_ok = (in_ch == '0);
      else                 word_ok = (in_ch == expected_ch);
    end
    commit = word_ok && (in_ch == LAST_CH);
  end

  // The last word goes straight into the committed frame; mode is looked at
  // only here, so mid-frame mode changes have no effect.
  always_comb begin
    raw_frame            = slots;
    raw_frame[NUM_CH-1]  = data;
    xf_frame             = raw_frame;
    case (mode_t'(mode))
      M_REV: begin
        for (int k = 0; k < NUM_CH; k++) xf_frame[k] = raw_frame[NUM_CH-1-k];
      end
      M_MUTE:  xf_frame = '0;
      default: xf_frame = raw_frame;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop     = out_vld && out_rdy;
    push    = commit && ((level != FULL_LVL) || pop);
    ovf_set = commit && !push;

    lvl_next = level;
    case ({push, pop})
      2'b10:   lvl_next = level + LVL_W'(1);
      2'b01:   lvl_next = level - LVL_W'(1);
      default: lvl_next = level;
    endcase

    rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // When the FIFO is (or becomes) empty apart from the new frame, the head
    // register must be fed from the push data, since the memory write lands
    // on the same edge.
    head_from_push = push && (pop ? (level == LVL_W'(1)) : (level == '0));
    head_next      = head_from_push ? FW'(xf_frame) : mem[rd_ptr_next];
  end

  // Frame assembly
  always_ff @(posedge sck or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (!rst_n) begin
      state       <= S_IDLE;
      expected_ch <= '0;
      slots       <= '0;
    end else if (word_ok) begin
      if (commit) begin
        state       <= S_IDLE;
        expected_ch <= '0;
      end else begin
        slots[in_ch] <= data;
        expected_ch  <= expected_ch + CH_W'(1);
        state        <= S_COLLECT;
      end
    end else if (in_vld) begin
      // Sequence error: the partial frame is abandoned. A channel-0 word
      // restarts a frame; anything else is dropped.
      if (in_ch == '0) begin
        slots[0]    <= data;
        expected_ch <= CH_W'(1);
        state       <= S_COLLECT;
      end else begin
        expected_ch <= '0;
        state       <= S_IDLE;
      end
    end
  end

  // FIFO storage
  // NOTE: the frame memory is deliberately not reset; it is only read at
  // addresses that have been written since reset, and a reset-free array
  // maps onto plain RAM.
  always_ff @(posedge sck) begin
    if (push) mem[wr_ptr] <= FW'(xf_frame);
  end

  // FIFO control, registered head and status flags
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_vld   <= 1'b0;
      out_frame <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_ptr_next;
      level   <= lvl_next;
      out_vld <= (lvl_next != '0);
      // Head only changes when something is there to show; while stalled
      // rd_ptr_next == rd_ptr and the same stored frame is reloaded.
      if (lvl_next != '0) out_frame <= head_next;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      frame_err <= in_vld && !word_ok;
    end
  end

endmodule
